// File: rtl/reg_scoreboard_if.sv
// reg_scoreboard_if
//   Groups the decode/writeback side of the RAW scoreboard into one bundle.
//   Ports (as signals of the bundle):
//     rs1_addr/rs2_addr, rs1_used/rs2_used : decode source operands
//     issue_valid/issue_we/issue_rd        : instruction presented to decode
//     wb_valid/wb_rd                       : register-file writeback
//     stall                                : decode hold (instruction not accepted)
//     outstanding                          : total pending writes, all registers
//     wb_underflow                         : sticky writeback-to-idle-register error
//   master = decode/writeback pipeline, slave = scoreboard.
interface reg_scoreboard_if #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int CNT_WIDTH     = 2
);
    logic [ADDRESS_WIDTH-1:0]           rs1_addr;
    logic [ADDRESS_WIDTH-1:0]           rs2_addr;
    logic                               rs1_used;
    logic                               rs2_used;
    logic                               issue_valid;
    logic                               issue_we;
    logic [ADDRESS_WIDTH-1:0]           issue_rd;
    logic                               wb_valid;
    logic [ADDRESS_WIDTH-1:0]           wb_rd;
    logic                               stall;
    logic [ADDRESS_WIDTH+CNT_WIDTH-1:0] outstanding;
    logic                               wb_underflow;

    modport master (
        output rs1_addr, rs2_addr, rs1_used, rs2_used,
        output issue_valid, issue_we, issue_rd,
        output wb_valid, wb_rd,
        input  stall, outstanding, wb_underflow
    );

    modport slave (
        input  rs1_addr, rs2_addr, rs1_used, rs2_used,
        input  issue_valid, issue_we, issue_rd,
        input  wb_valid, wb_rd,
        output stall, outstanding, wb_underflow
    );
endinterface

// File: rtl/reg_scoreboard.sv
// reg_scoreboard
//   Per-register RAW hazard tracker beside the decode-stage register file.
//   Each architectural register (except x0) owns a small pending-write counter,
//   raised when an instruction writing it issues and lowered on its writeback.
//   Decode stalls while a used source is still pending or the destination
//   counter is saturated.
//   Ports:
//     clk  : rising-edge clock
//     rst  : synchronous active-high reset
//     sb   : reg_scoreboard_if.slave (decode sources, issue, writeback,
//            stall / outstanding / wb_underflow outputs)

// Single register's pending-write counter.
//   inc : an accepted instruction allocates this register
//   dec : a writeback targets this register
//   Both in the same cycle cancel. A writeback to an idle counter is ignored
//   here (the error is flagged at the top level).
module reg_scoreboard_cnt #(
    parameter int CNT_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 dec,
    output logic [CNT_WIDTH-1:0] cnt
);
    localparam logic [CNT_WIDTH-1:0] ONE = 1;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (inc && !dec)
            cnt <= cnt + ONE;      // saturation is prevented by the issue stall
        else if (dec && !inc && cnt != '0)
            cnt <= cnt - ONE;
    end
endmodule

module reg_scoreboard #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int CNT_WIDTH     = 2
) (
    input logic           clk,
    input logic           rst,
    reg_scoreboard_if.slave sb
);
    localparam int NREG = 2 ** ADDRESS_WIDTH;
    localparam int OW   = ADDRESS_WIDTH + CNT_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;
    localparam logic [OW-1:0]        OUT_ONE = 1;

    logic [NREG-1:0][CNT_WIDTH-1:0] cnt;
    logic [NREG-1:0]                inc;
    logic [NREG-1:0]                dec;

    logic pend1, pend2, haz_a, haz_b, sat;
    logic alloc, wb_nz, wb_eff, underflow;
    logic [CNT_WIDTH-1:0] cnt_rs1, cnt_rs2, cnt_rd, cnt_wb;

    assign cnt_rs1 = cnt[sb.rs1_addr];
    assign cnt_rs2 = cnt[sb.rs2_addr];
    assign cnt_rd  = cnt[sb.issue_rd];
    assign cnt_wb  = cnt[sb.wb_rd];

    // A last outstanding write landing this cycle is not a hazard: the
    // register file writes on the falling edge, so decode sees the new value.
    // cnt[0] is tied to 0, so x0 never reads pending.
    assign pend1 = (cnt_rs1 != '0) &&
                   !(sb.wb_valid && sb.wb_rd == sb.rs1_addr && cnt_rs1 == CNT_ONE);
    assign pend2 = (cnt_rs2 != '0) &&
                   !(sb.wb_valid && sb.wb_rd == sb.rs2_addr && cnt_rs2 == CNT_ONE);

    assign haz_a = sb.rs1_used && pend1;
    assign haz_b = sb.rs2_used && pend2;

    // Full destination counter blocks a new allocation unless a writeback to
    // the same register frees a slot in the same cycle.
    assign sat = sb.issue_we && (sb.issue_rd != '0) && (cnt_rd == CNT_MAX) &&
                 !(sb.wb_valid && sb.wb_rd == sb.issue_rd);

    assign sb.stall = !rst && sb.issue_valid && (haz_a || haz_b || sat);

    assign alloc = sb.issue_valid && !sb.stall && sb.issue_we && (sb.issue_rd != '0);

    assign wb_nz = sb.wb_valid && (sb.wb_rd != '0);

    // A writeback counts as consumed when its counter is live, or when it
    // pairs with a same-cycle allocation of the same register (net zero).
    assign wb_eff = wb_nz && ((cnt_wb != '0) || (alloc && sb.issue_rd == sb.wb_rd));

    assign underflow = wb_nz && (cnt_wb == '0) && !(alloc && sb.issue_rd == sb.wb_rd);

    assign cnt[0] = '0;
    assign inc[0] = 1'b0;
    assign dec[0] = 1'b0;

    genvar r;
    generate
        for (r = 1; r < NREG; r++) begin : g_reg
            assign inc[r] = alloc && (sb.issue_rd == ADDRESS_WIDTH'(r));
            assign dec[r] = wb_nz && (sb.wb_rd == ADDRESS_WIDTH'(r));

            reg_scoreboard_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
                .clk (clk),
                .rst (rst),
                .inc (inc[r]),
                .dec (dec[r]),
                .cnt (cnt[r])
            );
        end
    endgenerate

    // Running sum of all counters, kept incrementally rather than by an adder tree.
    always_ff @(posedge clk) begin
        if (rst) begin
            sb.outstanding  <= '0;
            sb.wb_underflow <= 1'b0;
        end else begin
            case ({alloc, wb_eff})
                2'b10:   sb.outstanding <= sb.outstanding + OUT_ONE;
                2'b01:   sb.outstanding <= sb.outstanding - OUT_ONE;
                default: sb.outstanding <= sb.outstanding;
            endcase
            if (underflow)
                sb.wb_underflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard (ADDRESS_WIDTH=5, CNT_WIDTH=2).
// Inputs change 1 time unit after a rising edge; combinational stall is
// checked 1 unit after that, registered outputs 1 unit after the next edge.
module tb_reg_scoreboard;
    localparam int AW = 5;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nassert = 0;
    int   nfail   = 0;

    always #5 clk = ~clk;

    reg_scoreboard_if #(.ADDRESS_WIDTH(AW), .CNT_WIDTH(CW)) sbif ();

    reg_scoreboard #(.ADDRESS_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sbif.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nassert++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        sbif.rs1_addr = '0; sbif.rs2_addr = '0;
        sbif.rs1_used = 1'b0; sbif.rs2_used = 1'b0;
        sbif.issue_valid = 1'b0; sbif.issue_we = 1'b0; sbif.issue_rd = '0;
        sbif.wb_valid = 1'b0; sbif.wb_rd = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [AW-1:0] rd);
        sbif.issue_valid = 1'b1; sbif.issue_we = 1'b1; sbif.issue_rd = rd;
    endtask

    task automatic wb(input logic [AW-1:0] rd);
        sbif.wb_valid = 1'b1; sbif.wb_rd = rd;
    endtask

    task automatic rd1(input logic [AW-1:0] a);
        sbif.issue_valid = 1'b1; sbif.rs1_addr = a; sbif.rs1_used = 1'b1;
    endtask

    initial begin
        // T1 reset with random inputs
        idle();
        for (int i = 0; i < 2; i++) begin
            sbif.rs1_addr = AW'($urandom); sbif.rs2_addr = AW'($urandom);
            sbif.rs1_used = 1'($urandom);  sbif.rs2_used = 1'($urandom);
            sbif.issue_valid = 1'b1;       sbif.issue_we = 1'($urandom);
            sbif.issue_rd = AW'($urandom);
            sbif.wb_valid = 1'($urandom);  sbif.wb_rd = AW'($urandom);
            #1 chk("t1_stall_in_reset", sbif.stall, 0);
            tick();
        end
        rst = 1'b0;
        idle();
        #1;
        chk("t1_stall", sbif.stall, 0);
        chk("t1_outstanding", sbif.outstanding, 0);
        chk("t1_underflow", sbif.wb_underflow, 0);

        // T2 basic RAW and same-cycle writeback bypass
        issue(5); #1 chk("t2_issue_stall", sbif.stall, 0);
        tick(); idle();
        chk("t2_out1", sbif.outstanding, 1);
        rd1(5); #1 chk("t2_raw_stall", sbif.stall, 1);
        wb(5);  #1 chk("t2_bypass_stall", sbif.stall, 0);
        tick(); idle();
        chk("t2_out0", sbif.outstanding, 0);
        chk("t2_underflow", sbif.wb_underflow, 0);

        // T3 x0 never tracked; alloc+wb same idle reg is not an underflow
        issue(0); #1 chk("t3_issue_x0_stall", sbif.stall, 0);
        tick(); idle();
        chk("t3_out", sbif.outstanding, 0);
        rd1(0); wb(0); #1 chk("t3_read_x0_stall", sbif.stall, 0);
        tick(); idle();
        chk("t3_wb_x0_underflow", sbif.wb_underflow, 0);
        issue(12); wb(12); #1 chk("t3_pair_stall", sbif.stall, 0);
        tick(); idle();
        chk("t3_pair_underflow", sbif.wb_underflow, 0);
        chk("t3_pair_out", sbif.outstanding, 0);
        rd1(12); #1 chk("t3_pair_not_pending", sbif.stall, 0);
        idle();

        // T4 saturation on rd=7
        for (int i = 0; i < 3; i++) begin
            issue(7); #1 chk("t4_fill_stall", sbif.stall, 0);
            tick(); idle();
        end
        chk("t4_out3", sbif.outstanding, 3);
        issue(7); #1 chk("t4_sat_stall", sbif.stall, 1);
        tick();
        chk("t4_sat_no_alloc", sbif.outstanding, 3);
        wb(7); #1 chk("t4_sat_wb_stall", sbif.stall, 0);
        tick(); idle();
        chk("t4_sat_wb_out", sbif.outstanding, 3);
        rd1(7); wb(7); #1 chk("t4_cnt3_wb_still_pending", sbif.stall, 1);
        tick(); idle();
        chk("t4_drain_out2", sbif.outstanding, 2);
        wb(7); tick(); idle();
        rd1(7); wb(7); #1 chk("t4_last_wb_bypass", sbif.stall, 0);
        tick(); idle();
        chk("t4_drain_out0", sbif.outstanding, 0);
        chk("t4_underflow", sbif.wb_underflow, 0);

        // T5 simultaneous alloc and writeback
        issue(3); tick(); idle();
        chk("t5_out1", sbif.outstanding, 1);
        issue(3); wb(3); #1 chk("t5_pair_stall", sbif.stall, 0);
        tick(); idle();
        chk("t5_pair_out", sbif.outstanding, 1);
        sbif.issue_valid = 1'b1; sbif.rs2_addr = 3; sbif.rs2_used = 1'b1;
        #1 chk("t5_rs2_stall", sbif.stall, 1);
        idle();
        issue(4); wb(3); #1 chk("t5_diff_stall", sbif.stall, 0);
        tick(); idle();
        chk("t5_diff_out", sbif.outstanding, 1);
        sbif.issue_valid = 1'b1; sbif.rs2_addr = 3; sbif.rs2_used = 1'b1;
        #1 chk("t5_r3_free", sbif.stall, 0);
        idle();
        rd1(4); #1 chk("t5_r4_pending", sbif.stall, 1);
        idle(); wb(4); tick(); idle();
        chk("t5_out0", sbif.outstanding, 0);
        chk("t5_underflow", sbif.wb_underflow, 0);

        // T6 underflow, unused source, reset mid-operation
        wb(9); tick(); idle();
        chk("t6_underflow_set", sbif.wb_underflow, 1);
        chk("t6_underflow_out", sbif.outstanding, 0);
        issue(10); tick(); idle();
        chk("t6_out1", sbif.outstanding, 1);
        sbif.issue_valid = 1'b1; sbif.rs1_addr = 10; sbif.rs1_used = 1'b0;
        #1 chk("t6_unused_src", sbif.stall, 0);
        sbif.rs1_used = 1'b1; sbif.issue_valid = 1'b0;
        #1 chk("t6_no_issue_no_stall", sbif.stall, 0);
        idle();
        rd1(10); #1 chk("t6_used_src", sbif.stall, 1);
        idle(); tick(); tick();
        chk("t6_underflow_sticky", sbif.wb_underflow, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t6_rst_underflow", sbif.wb_underflow, 0);
        chk("t6_rst_out", sbif.outstanding, 0);
        rd1(10); #1 chk("t6_rst_not_pending", sbif.stall, 0);
        idle(); wb(10); tick(); idle();
        chk("t6_post_rst_underflow", sbif.wb_underflow, 1);
        chk("t6_post_rst_out", sbif.outstanding, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end
endmodule
